// File: rtl/bilin_pkg.sv
// bilin_pkg: shared defaults and FSM encoding for the bilinear line feeder.
// No ports. Build option BILIN_CENTER_EN is consumed by bilin_phase_acc.
package bilin_pkg;
    localparam int PIX_W    = 8;
    localparam int CNT_W    = 12;
    localparam int FRAC_W   = 8;
    localparam int STEP_W   = 16;
    localparam int ONE_FP   = 256;
    localparam int HALF_PIX = ONE_FP / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME0,
        ST_PRIME1,
        ST_RUN,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/bilin_phase_acc.sv
// bilin_phase_acc: saturating 8.8-style phase accumulator (DDA) with I/F split.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   init         load start phase and latch step (step==0 treated as 1)
//   adv          add latched step, saturating at all-ones
//   step         phase increment, unsigned fixed point
//   int_part     integer part of the phase (source pixel index)
//   frac_part    fractional part of the phase (weight toward right pixel)
// Build option BILIN_CENTER_EN: start phase = max(0, step/2 - half pixel),
// otherwise the start phase is 0 (left-edge alignment).
module bilin_phase_acc #(
    parameter int CNT_W  = bilin_pkg::CNT_W,
    parameter int FRAC_W = bilin_pkg::FRAC_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init,
    input  logic                          adv,
    input  logic [bilin_pkg::STEP_W-1:0]  step,
    output logic [CNT_W-1:0]              int_part,
    output logic [FRAC_W-1:0]             frac_part
);
    import bilin_pkg::*;

    localparam int ACC_W = CNT_W + FRAC_W;

    logic [ACC_W-1:0]  acc;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_eff;
    logic [ACC_W-1:0]  init_val;
    logic [ACC_W:0]    sum;

    assign step_eff = (step == '0) ? STEP_W'(1) : step;

`ifdef BILIN_CENTER_EN
    logic [STEP_W-1:0] step_half;
    assign step_half = step_eff >> 1;
    assign init_val  = (step_half > STEP_W'(HALF_PIX))
                     ? {{(ACC_W-STEP_W){1'b0}}, step_half - STEP_W'(HALF_PIX)}
                     : '0;
`else
    assign init_val = '0;
`endif

    // One spare bit catches the carry so the add can clamp instead of wrapping.
    assign sum = {1'b0, acc} + {{(ACC_W+1-STEP_W){1'b0}}, step_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            step_q <= '0;
        end else if (init) begin
            acc    <= init_val;
            step_q <= step_eff;
        end else if (adv) begin
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    end

    assign int_part  = acc[ACC_W-1:FRAC_W];
    assign frac_part = acc[FRAC_W-1:0];
endmodule

// File: rtl/bilin_line_feeder.sv
// bilin_line_feeder: feeds one line of pixels to a free-running bilinear
// interpolator as (Din1, Din2, Kremain) triples, stepping a phase accumulator
// for up/down scaling, replicating the right edge and draining the line tail.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start                           begin a line, samples cfg_* (ignored while busy)
//   cfg_step, cfg_in_w, cfg_out_w   phase step, input/output line lengths
//   in_valid, in_data, in_ready     input pixel stream
//   out_valid, Din1, Din2, Kremain  output sample (registered, no backpressure)
//   out_last                        final sample of the line
//   busy, done                      line in progress / one-cycle completion pulse
// Build option BILIN_CENTER_EN (inside bilin_phase_acc) selects pixel-centre alignment.
//
// state  | meaning
// IDLE   | waiting for start
// PRIME0 | loading left window pixel
// PRIME1 | loading right window pixel
// RUN    | emitting samples or shifting the window
// DRAIN  | discarding leftover line pixels, then done
module bilin_line_feeder #(
    parameter int PIX_W  = bilin_pkg::PIX_W,
    parameter int CNT_W  = bilin_pkg::CNT_W,
    parameter int FRAC_W = bilin_pkg::FRAC_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [bilin_pkg::STEP_W-1:0]  cfg_step,
    input  logic [CNT_W-1:0]              cfg_in_w,
    input  logic [CNT_W-1:0]              cfg_out_w,
    input  logic                          in_valid,
    input  logic [PIX_W-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [PIX_W-1:0]              Din1,
    output logic [PIX_W-1:0]              Din2,
    output logic [FRAC_W-1:0]             Kremain,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);
    import bilin_pkg::*;

    state_t            state;
    logic [CNT_W-1:0]  in_w_q;
    logic [CNT_W-1:0]  out_w_q;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  wi;
    logic [PIX_W-1:0]  p0;
    logic [PIX_W-1:0]  p1;

    logic [CNT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
    logic              at_edge;
    logic              need_shift;
    logic              emit;
    logic              take;

    bilin_phase_acc #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      ((state == ST_IDLE) && start),
        .adv       (emit),
        .step      (cfg_step),
        .int_part  (int_part),
        .frac_part (frac_part)
    );

    // Replicate the last pixel only once the window actually holds it; if the
    // phase jumps past the edge while the window lags, keep shifting first.
    assign at_edge    = (int_part >= (in_w_q - CNT_W'(1)))
                     && (({1'b0, wi} + (CNT_W+1)'(2)) >= {1'b0, in_w_q});
    assign need_shift = !at_edge && (int_part != wi);
    assign emit       = (state == ST_RUN) && !need_shift;
    assign take       = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_PRIME0, ST_PRIME1: in_ready = 1'b1;
            ST_RUN:               in_ready = need_shift;
            ST_DRAIN:             in_ready = (in_cnt != in_w_q);
            default:              in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_w_q    <= '0;
            out_w_q   <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            wi        <= '0;
            p0        <= '0;
            p1        <= '0;
            out_valid <= 1'b0;
            Din1      <= '0;
            Din2      <= '0;
            Kremain   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            if (take) in_cnt <= in_cnt + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        in_w_q  <= cfg_in_w;
                        out_w_q <= cfg_out_w;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        wi      <= '0;
                        busy    <= 1'b1;
                        state   <= ST_PRIME0;
                    end
                end
                ST_PRIME0: begin
                    if (take) begin
                        p0 <= in_data;
                        wi <= '0;
                        if (in_w_q == CNT_W'(1)) begin
                            p1    <= in_data;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_PRIME1;
                        end
                    end
                end
                ST_PRIME1: begin
                    if (take) begin
                        p1    <= in_data;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (need_shift) begin
                        if (take) begin
                            p0 <= p1;
                            p1 <= in_data;
                            wi <= wi + CNT_W'(1);
                        end
                    end else begin
                        out_valid <= 1'b1;
                        Din1      <= at_edge ? p1 : p0;
                        Din2      <= p1;
                        Kremain   <= at_edge ? '0 : frac_part;
                        out_cnt   <= out_cnt + CNT_W'(1);
                        if (out_cnt == (out_w_q - CNT_W'(1))) begin
                            out_last <= 1'b1;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (in_cnt == in_w_q) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
